// File: rtl/spi_master_tx_if.sv
// Word-level handshake bundle between the command/pixel sequencer and spi_master_tx.
// The master modport is the word source; the slave modport is the SPI block.
interface spi_master_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_dc;
    logic              tx_last;

    modport master (output tx_valid, output tx_data, output tx_dc, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_dc, input tx_last, output tx_ready);
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 write master for the ILI9341 panel: per-word D/C, CS held across bursts.
// Define SPI_RX_EN to add miso capture (i_miso, o_rx_data, o_rx_valid).
module spi_master_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_master_tx_if.slave    tx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_dc
`ifdef SPI_RX_EN
    ,
    input  logic              i_miso,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid
`endif
);
    localparam int CNT_MAX = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_HOLD, S_BURST} state_t;

    state_t            r_state, w_nxt_state;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [PH_W-1:0]   r_phase, w_nxt_phase;
    logic [DATA_W-1:0] r_shreg, w_nxt_shreg;
    logic              r_dc, w_nxt_dc;
    logic              r_last, w_nxt_last;
    logic              w_accept;

    assign tx.tx_ready = (r_state == S_IDLE || r_state == S_BURST) && !i_rst;
    assign w_accept    = tx.tx_valid && tx.tx_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_phase = r_phase;
        w_nxt_shreg = r_shreg;
        w_nxt_dc    = r_dc;
        w_nxt_last  = r_last;
        case (r_state)
            S_IDLE, S_BURST: begin
                if (w_accept) begin
                    w_nxt_state = S_SETUP;
                    w_nxt_cnt   = '0;
                    w_nxt_phase = '0;
                    w_nxt_shreg = tx.tx_data;
                    w_nxt_dc    = tx.tx_dc;
                    w_nxt_last  = tx.tx_last;
                end
            end
            S_SETUP: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == DIV_LAST) begin
                    w_nxt_state = S_SHIFT;
                    w_nxt_cnt   = '0;
                    w_nxt_phase = '0;
                end
            end
            S_SHIFT: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == DIV_LAST) begin
                    w_nxt_cnt = '0;
                    if (r_phase == PH_LAST) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_phase = r_phase + PH_W'(1);
                        // leaving an sclk-high phase: present the next bit
                        if (!r_phase[0]) w_nxt_shreg = r_shreg << 1;
                    end
                end
            end
            S_DONE: begin
                w_nxt_cnt = '0;
                if (r_last) w_nxt_state = (CS_HOLD > 0) ? S_HOLD : S_IDLE;
                else        w_nxt_state = S_BURST;
            end
            S_HOLD: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == HOLD_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Pins are registered from next-state values so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= '0;
            r_shreg <= '0;
            r_dc    <= 1'b0;
            r_last  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
            o_cs_n  <= 1'b1;
            o_dc    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_phase <= w_nxt_phase;
            r_shreg <= w_nxt_shreg;
            r_dc    <= w_nxt_dc;
            r_last  <= w_nxt_last;
            o_busy  <= (w_nxt_state != S_IDLE);
            o_done  <= (w_nxt_state == S_DONE);
            o_sclk  <= (w_nxt_state == S_SHIFT) && !w_nxt_phase[0];
            o_mosi  <= w_nxt_shreg[DATA_W-1];
            o_cs_n  <= (w_nxt_state == S_IDLE);
            o_dc    <= w_nxt_dc;
        end
    end

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] r_rx_sh;

    // miso is taken on the last clk of each sclk-high phase, first bit ending up as MSB
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_sh    <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            if (r_state == S_SHIFT && !r_phase[0] && r_cnt == DIV_LAST)
                r_rx_sh <= (r_rx_sh << 1) | DATA_W'(i_miso);
            o_rx_valid <= (w_nxt_state == S_DONE);
            if (w_nxt_state == S_DONE) o_rx_data <= r_rx_sh;
        end
    end
`endif
endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: an 8-bit/div-2 instance and a 16-bit/div-1 instance.
// Cycle numbers are relative to the sample where a handshake is seen (cycle 0).
module tb_spi_master_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    spi_master_tx_if #(.DATA_W(8))  if8 ();
    spi_master_tx_if #(.DATA_W(16)) if16 ();

    logic busy8, done8, sclk8, mosi8, cs_n8, dc8;
    logic busy16, done16, sclk16, mosi16, cs_n16, dc16;
`ifdef SPI_RX_EN
    logic        miso8, miso16, rx_valid8, rx_valid16;
    logic [7:0]  rx_data8;
    logic [15:0] rx_data16;
    logic [31:0] rx_word;
    int          n_rx_bad;
`endif

    spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .CS_HOLD(1)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .tx(if8),
        .o_busy(busy8), .o_done(done8), .o_sclk(sclk8), .o_mosi(mosi8), .o_cs_n(cs_n8), .o_dc(dc8)
`ifdef SPI_RX_EN
        , .i_miso(miso8), .o_rx_data(rx_data8), .o_rx_valid(rx_valid8)
`endif
    );

    spi_master_tx #(.DATA_W(16), .CLK_DIV(1), .CS_HOLD(1)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .tx(if16),
        .o_busy(busy16), .o_done(done16), .o_sclk(sclk16), .o_mosi(mosi16), .o_cs_n(cs_n16), .o_dc(dc16)
`ifdef SPI_RX_EN
        , .i_miso(miso16), .o_rx_data(rx_data16), .o_rx_valid(rx_valid16)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_hs, n_rise, n_toggle, n_done, done_cyc, cs_first, cs_last, n_cs_rise;
    int dc_rise, n_dc_hi, n_ready_bad, win_lo, win_hi;
    int acc_cyc [4];
    logic [31:0] mosi_word;
    bit   hs_now;
    logic prev_sclk, prev_cs_n, prev_dc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input bit sel);
        n_hs = 0; n_rise = 0; n_toggle = 0; n_done = 0; done_cyc = -1;
        cs_first = -1; cs_last = -1; n_cs_rise = 0; dc_rise = -1; n_dc_hi = 0;
        n_ready_bad = 0; win_lo = 1; win_hi = 0; mosi_word = '0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        prev_sclk = sel ? sclk16 : sclk8;
        prev_cs_n = sel ? cs_n16 : cs_n8;
        prev_dc   = sel ? dc16 : dc8;
`ifdef SPI_RX_EN
        n_rx_bad = 0; rx_word = '0;
`endif
    endtask

    // one negedge sample of the selected instance, accumulating observations
    task automatic step(input bit sel);
        logic s_rdy, s_vld, s_last, s_sclk, s_mosi, s_done, s_cs_n, s_dc;
        @(negedge clk);
        cyc++;
        s_rdy  = sel ? if16.tx_ready : if8.tx_ready;
        s_vld  = sel ? if16.tx_valid : if8.tx_valid;
        s_last = sel ? if16.tx_last  : if8.tx_last;
        s_sclk = sel ? sclk16 : sclk8;
        s_mosi = sel ? mosi16 : mosi8;
        s_done = sel ? done16 : done8;
        s_cs_n = sel ? cs_n16 : cs_n8;
        s_dc   = sel ? dc16   : dc8;
        hs_now = s_vld && s_rdy;
        if (s_rdy && cyc >= win_lo && cyc <= win_hi) n_ready_bad++;
        if (hs_now) begin
            if (n_hs < 4) acc_cyc[n_hs] = cyc;
            n_hs++;
            win_lo = cyc + 1;
            win_hi = cyc + (sel ? 34 : 35) + (s_last ? 1 : 0);
        end
        if (s_sclk && !prev_sclk) begin
            n_rise++;
            mosi_word = {mosi_word[30:0], s_mosi};
        end
        if (s_sclk != prev_sclk) n_toggle++;
        if (s_done) begin n_done++; done_cyc = cyc; end
        if (!s_cs_n && cs_first < 0) cs_first = cyc;
        if (!s_cs_n) cs_last = cyc;
        if (s_cs_n && !prev_cs_n) n_cs_rise++;
        if (s_dc && !prev_dc) dc_rise = cyc;
        if (s_dc) n_dc_hi++;
`ifdef SPI_RX_EN
        if (!sel) begin
            if (rx_valid8 != done8) n_rx_bad++;
            if (rx_valid8) rx_word = 32'(rx_data8);
        end
`endif
        prev_sclk = s_sclk; prev_cs_n = s_cs_n; prev_dc = s_dc;
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic c, input logic l);
        if8.tx_valid = v; if8.tx_data = d; if8.tx_dc = c; if8.tx_last = l;
    endtask

    logic [7:0] bw_data [3];
    logic       bw_dc   [3];
    logic       bw_last [3];
    int         widx;
    bit         reached;

    initial begin
        rst = 1'b1;
        drive8(1'b0, 8'h00, 1'b0, 1'b0);
        if16.tx_valid = 1'b0; if16.tx_data = '0; if16.tx_dc = 1'b0; if16.tx_last = 1'b0;
`ifdef SPI_RX_EN
        miso8 = 1'b0; miso16 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs_n", cs_n8, 1'b1);
        check_eq("rst_sclk", sclk8, 1'b0);
        check_eq("rst_mosi", mosi8, 1'b0);
        check_eq("rst_dc", dc8, 1'b0);
        check_eq("rst_done", done8, 1'b0);
        check_eq("rst_busy", busy8, 1'b0);
        check_eq("rst_ready", if8.tx_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", if8.tx_ready, 1'b1);

        // single word 0xA5, inputs scrambled after accept
        clear_stats(0);
        @(posedge clk); #1;
        drive8(1'b1, 8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 45; i++) begin
            step(0);
            @(posedge clk); #1;
            if (hs_now) drive8(1'b0, 8'hFF, 1'b1, 1'b0);
        end
        check_eq("w1_hs", n_hs, 1);
        check_eq("w1_mosi", mosi_word & 32'hFF, 32'hA5);
        check_eq("w1_rises", n_rise, 8);
        check_eq("w1_done_cyc", done_cyc - acc_cyc[0], 35);
        check_eq("w1_done_cnt", n_done, 1);
        check_eq("w1_cs_first", cs_first - acc_cyc[0], 1);
        check_eq("w1_cs_last", cs_last - acc_cyc[0], 36);
        check_eq("w1_dc_hi", n_dc_hi, 0);
        check_eq("w1_ready", n_ready_bad, 0);

        // burst 0x2C / 0x12 / 0x34 with valid held
        bw_data[0] = 8'h2C; bw_dc[0] = 1'b0; bw_last[0] = 1'b0;
        bw_data[1] = 8'h12; bw_dc[1] = 1'b1; bw_last[1] = 1'b0;
        bw_data[2] = 8'h34; bw_dc[2] = 1'b1; bw_last[2] = 1'b1;
        clear_stats(0);
        widx = 0;
        drive8(1'b1, bw_data[0], bw_dc[0], bw_last[0]);
        for (int i = 0; i < 130; i++) begin
            step(0);
            @(posedge clk); #1;
            if (hs_now) begin
                widx++;
                if (widx < 3) drive8(1'b1, bw_data[widx], bw_dc[widx], bw_last[widx]);
                else          if8.tx_valid = 1'b0;
            end
        end
        check_eq("b_hs", n_hs, 3);
        check_eq("b_done_cnt", n_done, 3);
        check_eq("b_acc1", acc_cyc[1] - acc_cyc[0], 36);
        check_eq("b_acc2", acc_cyc[2] - acc_cyc[0], 72);
        check_eq("b_cs_rise", n_cs_rise, 1);
        check_eq("b_cs_last", cs_last - acc_cyc[0], 108);
        check_eq("b_dc_rise", dc_rise - acc_cyc[0], 37);
        check_eq("b_mosi", mosi_word & 32'hFFFFFF, 32'h2C1234);
        check_eq("b_rises", n_rise, 24);
        check_eq("b_ready", n_ready_bad, 0);

        // backpressure: a second word is offered throughout the first
        clear_stats(0);
        widx = 0;
        drive8(1'b1, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 90; i++) begin
            step(0);
            @(posedge clk); #1;
            if (hs_now) begin
                widx++;
                if (widx == 1) drive8(1'b1, 8'hC3, 1'b0, 1'b1);
                else           if8.tx_valid = 1'b0;
            end
        end
        check_eq("bp_hs", n_hs, 2);
        check_eq("bp_done_cnt", n_done, 2);
        check_eq("bp_acc1", acc_cyc[1] - acc_cyc[0], 37);
        check_eq("bp_mosi", mosi_word & 32'hFFFF, 32'h5AC3);
        check_eq("bp_ready", n_ready_bad, 0);

        // reset while in SHIFT phase 5
        clear_stats(0);
        reached = 1'b0;
        drive8(1'b1, 8'h3E, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !reached; i++) begin
            step(0);
            if (acc_cyc[0] >= 0 && cyc - acc_cyc[0] == 13) begin
                check_eq("rs_pre_rises", n_rise, 3);
                reached = 1'b1;
            end
            @(posedge clk); #1;
            if (hs_now) if8.tx_valid = 1'b0;
            if (reached) rst = 1'b1;
        end
        check_eq("rs_reach_p5", reached, 1'b1);
        step(0);
        step(0);
        check_eq("rs_cs_n", cs_n8, 1'b1);
        check_eq("rs_sclk", sclk8, 1'b0);
        check_eq("rs_mosi", mosi8, 1'b0);
        check_eq("rs_busy", busy8, 1'b0);
        check_eq("rs_ready", if8.tx_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) step(0);
        check_eq("rs_no_done", n_done, 0);

        clear_stats(0);
        @(posedge clk); #1;
        drive8(1'b1, 8'h96, 1'b1, 1'b1);
        for (int i = 0; i < 45; i++) begin
            step(0);
            @(posedge clk); #1;
            if (hs_now) if8.tx_valid = 1'b0;
        end
        check_eq("ra_mosi", mosi_word & 32'hFF, 32'h96);
        check_eq("ra_done_cyc", done_cyc - acc_cyc[0], 35);
        check_eq("ra_dc_rise", dc_rise - acc_cyc[0], 1);

        // 16-bit word at the fastest divider
        clear_stats(1);
        if16.tx_valid = 1'b1; if16.tx_data = 16'h8001; if16.tx_dc = 1'b0; if16.tx_last = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step(1);
            @(posedge clk); #1;
            if (hs_now) if16.tx_valid = 1'b0;
        end
        check_eq("d1_mosi", mosi_word & 32'hFFFF, 32'h8001);
        check_eq("d1_rises", n_rise, 16);
        check_eq("d1_toggles", n_toggle, 32);
        check_eq("d1_done_cyc", done_cyc - acc_cyc[0], 34);
        check_eq("d1_ready", n_ready_bad, 0);

`ifdef SPI_RX_EN
        begin
            logic [7:0] rx_pat;
            int         rx_idx;
            logic       drv_prev_sclk;
            rx_pat = 8'h3C;
            rx_idx = -1;
            drv_prev_sclk = sclk8;
            clear_stats(0);
            drive8(1'b1, 8'h00, 1'b0, 1'b1);
            for (int i = 0; i < 45; i++) begin
                step(0);
                @(posedge clk); #1;
                if (hs_now) begin
                    if8.tx_valid = 1'b0;
                    rx_idx = 7;
                    miso8 = rx_pat[7];
                end else if (drv_prev_sclk && !sclk8 && rx_idx > 0) begin
                    rx_idx--;
                    miso8 = rx_pat[rx_idx];
                end
                drv_prev_sclk = sclk8;
            end
            check_eq("rx_data", rx_word, 32'h3C);
            check_eq("rx_valid_align", n_rx_bad, 0);
            check_eq("rx_done_cnt", n_done, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Parametrised SPI write master for the ILI9341 path. Successor to the fixed 8-bit shift controller.
- Adds a programmable SCLK divider, generic word width and a valid/ready word interface.
- Adds a D/C line registered per word, and CS held low across multi-word bursts.
- Sits between the command/pixel sequencer and the panel pins.

Parameters:
- DATA_W, 8: bits per word, shifted MSB first; legal range ≥1.
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range ≥1, so the fastest SCLK is clk/2.
- CS_HOLD, 1: clk cycles cs_n stays low after the last word of a burst; legal range ≥0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_valid  in  1  word available.
- tx_ready  out  1  block can accept a word this cycle.
- tx_data  in  DATA_W  word to send.
- tx_dc  in  1  D/C level for this word (0 = command, 1 = data).
- tx_last  in  1  release CS after this word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at word completion.
- sclk  out  1  SPI clock, mode 0, idle low.
- mosi  out  1  serial data.
- cs_n  out  1  chip select, active-low.
- dc  out  1  panel D/C pin.

Behaviour:
- Reset and register rules:
  - All pin outputs are registered; there is no combinational clk-to-sclk path.
  - rst is sampled on the rising clk edge and takes priority over everything, including mid-word.
  - Values during and after reset: state=IDLE, cs_n=1, sclk=0, mosi=0, dc=0, done=0, busy=0.
  - Reset mid-word aborts the transfer with no done pulse. cs_n rises at the next edge.
- Handshake:
  - tx_ready = (state==IDLE || state==BURST) && !rst.
  - A word is accepted on the edge where tx_valid && tx_ready.
  - tx_data, tx_dc and tx_last are latched on that edge. Later changes on these inputs are ignored until the next accept.
- States:
  - IDLE: cs_n=1, sclk=0. On accept go to SETUP.
  - SETUP (CLK_DIV cycles): cs_n=0, dc=latched dc, mosi=data[DATA_W-1], sclk=0. Then go to SHIFT.
  - SHIFT: 2*DATA_W phases of CLK_DIV cycles each, phase index p = 0..2*DATA_W-1. A divider counter wraps at CLK_DIV-1; a phase counter counts p.
    - Even p: sclk=1; the rising edge occurs at phase entry and the slave samples here.
    - Odd p: sclk=0; the shift register shifts left at entry and mosi takes the next bit.
    - After the final phase go to DONE.
  - DONE (1 cycle): done=1, sclk=0, cs_n=0. If latched last: go to HOLD if CS_HOLD>0, otherwise IDLE. If not last: go to BURST.
  - HOLD (CS_HOLD cycles): cs_n=0, then go to IDLE.
  - BURST: cs_n=0, sclk=0, tx_ready=1. Waits indefinitely for the next word; on accept go to SETUP with CS still low.
- Latency, accept edge = cycle 0:
  - SETUP occupies cycles 1..CLK_DIV.
  - SHIFT occupies the next 2*DATA_W*CLK_DIV cycles.
  - done is high at cycle CLK_DIV*(2*DATA_W+1)+1, which is 35 for 8/2.
- Boundaries and edge cases:
  - tx_valid during DONE, HOLD or SHIFT is ignored (ready=0). The source must hold valid.
  - tx_dc may differ between words of a burst; dc updates at the SETUP entry edge only.
  - The word after the final one keeps its latched state; it is never sampled by the panel.
  - The divider and phase counters reset to 0 on every SETUP entry.

Optional Feature:
- Macro: SPI_RX_EN.
- When defined:
  - Adds input miso (1 bit) and outputs rx_data (DATA_W bits) and rx_valid (1 bit).
  - miso is sampled on the last clk cycle of each even (sclk high) phase and shifted into rx_data LSB-first-in, giving MSB-first order.
  - rx_valid pulses together with done; rx_data holds its value until the next done.
- When undefined: the ports and logic are absent and the TX behaviour is identical.

Test Plan:
- Reset, then a single word (DATA_W=8, CLK_DIV=2), tx_data=0xA5, tx_dc=0, tx_last=1 → required response:
  - MOSI at the 8 sclk rising edges reads 1,0,1,0,0,1,0,1.
  - done at cycle 35.
  - cs_n low from cycle 1 through cycle 36, then high.
  - dc=0 throughout.
- Burst: 0x2C (dc=0, last=0), then 0x12 and 0x34 (dc=1, last=1 on 0x34), tx_valid held → required response:
  - cs_n never rises between words.
  - dc switches to 1 at the second SETUP.
  - Three done pulses.
  - tx_ready high only in BURST/IDLE.
- Backpressure: tx_valid asserted continuously while in SHIFT → no accept until BURST/IDLE; word count equals handshake count.
- Reset asserted in SHIFT phase p=5 → required response:
  - Next edge: cs_n=1, sclk=0, mosi=0, busy=0.
  - No done pulse.
  - The next word transfers cleanly.
- CLK_DIV=1, DATA_W=16, 0x8001 → sclk toggles every clk, MSB and LSB both 1, done at cycle 34.
- SPI_RX_EN defined, miso driven 0x3C synchronously to sclk → rx_data=0x3C with rx_valid coincident with done.
